// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int MIN_DIV = 2;

  // Ratios below MIN_DIV cannot produce both a high and a low phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < 32'(MIN_DIV)) ? 32'(MIN_DIV) : n;
  endfunction
endpackage

// File: rtl/clk_div_if.sv
// Divide-ratio configuration handshake (valid/ready).
interface clk_div_if #(parameter int DIV_W = 8);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_core.sv
// Period counter and registered clk_out/tick generation for one divide ratio.
module clk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             boundary_o,
  output logic             clk_o,
  output logic             tick_o
);
  localparam logic [DIV_W:0]   ONE_W = (DIV_W+1)'(1);
  localparam logic [DIV_W-1:0] ONE_N = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d, tick_q, tick_d;
  logic [DIV_W:0]   half, cnt_nxt;

  // One extra bit so the largest ratio does not wrap in (N+1)>>1.
  assign half       = ({1'b0, div_i} + ONE_W) >> 1;
  assign cnt_nxt    = {1'b0, cnt_q} + ONE_W;
  assign boundary_o = run_i && (cnt_q == div_i - ONE_N);

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (!run_i || boundary_o) begin
      cnt_d  = '0;
      clk_d  = restart_i;
      tick_d = restart_i;
    end else begin
      cnt_d  = cnt_nxt[DIV_W-1:0];
      clk_d  = (cnt_nxt < half);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: run/drain FSM, ratio handshake, glitch-free ratio apply at period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  clk_div_if.slave         cfg,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             active,
  output logic [DIV_W-1:0] cur_div
);
  state_t           state_q;
  logic [DIV_W-1:0] cur_div_q, pend_div_q, cfg_clamped;
  logic             pend_vld_q, xfer, boundary, run, restart;

  assign cfg.cfg_ready = !pend_vld_q;
  assign xfer          = cfg.cfg_valid && !pend_vld_q;
  assign cfg_clamped   = DIV_W'(clamp_div(32'(cfg.cfg_div)));

  assign run     = (state_q != IDLE);
  // RUN always starts another period; elsewhere only if en asks for it.
  assign restart = (state_q == RUN) || en;

  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .clk_in     (clk_in),
    .rst        (rst),
    .run_i      (run),
    .restart_i  (restart),
    .div_i      (cur_div_q),
    .boundary_o (boundary),
    .clk_o      (clk_out),
    .tick_o     (tick_rise)
  );

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q    <= IDLE;
      cur_div_q  <= DIV_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) cur_div_q <= cfg_clamped;
          if (en)   state_q   <= RUN;
        end
        RUN, DRAIN: begin
          if (boundary && pend_vld_q) begin
            cur_div_q  <= pend_div_q;
            pend_vld_q <= 1'b0;
          end
          // Captured after the apply so a same-cycle offer waits for the next boundary.
          if (xfer) begin
            pend_div_q <= cfg_clamped;
            pend_vld_q <= 1'b1;
          end
          if (state_q == RUN) begin
            if (!en) state_q <= DRAIN;
          end else if (en) begin
            state_q <= RUN;
          end else if (boundary) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign active  = (state_q != IDLE);
  assign cur_div = cur_div_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl.
module tb_clk_div_ctrl;
  logic       clk_in = 1'b0;
  logic       rst, en;
  logic       clk_out, tick_rise, active;
  logic [7:0] cur_div;
  int         n_checks = 0;
  int         n_fail   = 0;

  clk_div_if #(.DIV_W(8)) cfg_if ();

  clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg_if),
    .clk_out   (clk_out),
    .tick_rise (tick_rise),
    .active    (active),
    .cur_div   (cur_div)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Records n samples of clk_out/tick_rise, first sample lands in the highest used bit.
  task automatic cap(input int n, output logic [31:0] co, output logic [31:0] tr);
    co = '0;
    tr = '0;
    for (int i = 0; i < n; i++) begin
      co = {co[30:0], clk_out};
      tr = {tr[30:0], tick_rise};
      if (i < n - 1) tick();
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    en = 1'b0;
    while (active && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: active=%b after %0d cycles, required 0", active, k);
    end
  endtask

  task automatic load_idle(input logic [7:0] d);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = d;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] co, tr;
    rst = 1'b0; en = 1'b0; cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = '0;
    tick(); tick();
    n_checks++;
    if ({clk_out, tick_rise, active, cfg_if.cfg_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_outputs: clk/tick/active/ready=%b, required 0001",
               {clk_out, tick_rise, active, cfg_if.cfg_ready});
    end
    n_checks++;
    if (cur_div !== 8'd4) begin
      n_fail++;
      $display("FAIL reset_cur_div: got %0d, required 4", cur_div);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (clk_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_clk_out: got %b, required 0", clk_out);
    end
    en = 1'b1;
    tick();
    cap(8, co, tr);
    n_checks++;
    if (co[7:0] !== 8'b11001100 || tr[7:0] !== 8'b10001000) begin
      n_fail++;
      $display("FAIL start_n4: clk=%b tick=%b, required 11001100 10001000", co[7:0], tr[7:0]);
    end
  endtask

  task automatic test_ratio_change();
    logic [31:0] co, tr;
    tick(); tick();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 8'd3;
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b0 || cur_div !== 8'd4) begin
      n_fail++;
      $display("FAIL pend_hold: ready=%b cur_div=%0d, required 0 and 4", cfg_if.cfg_ready, cur_div);
    end
    cap(8, co, tr);
    n_checks++;
    if (co[7:0] !== 8'b00110110 || tr[7:0] !== 8'b00100100) begin
      n_fail++;
      $display("FAIL change_4_to_3: clk=%b tick=%b, required 00110110 00100100", co[7:0], tr[7:0]);
    end
    n_checks++;
    if (cur_div !== 8'd3 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL applied_3: cur_div=%0d ready=%b, required 3 and 1", cur_div, cfg_if.cfg_ready);
    end
  endtask

  task automatic test_clamp_odd();
    logic [31:0] co, tr;
    wait_idle();
    load_idle(8'd1);
    n_checks++;
    if (cur_div !== 8'd2 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_1: cur_div=%0d ready=%b, required 2 and 1", cur_div, cfg_if.cfg_ready);
    end
    en = 1'b1;
    tick();
    cap(6, co, tr);
    n_checks++;
    if (co[5:0] !== 6'b101010 || tr[5:0] !== 6'b101010) begin
      n_fail++;
      $display("FAIL wave_n2: clk=%b tick=%b, required 101010 101010", co[5:0], tr[5:0]);
    end
    wait_idle();
    load_idle(8'd5);
    n_checks++;
    if (cur_div !== 8'd5) begin
      n_fail++;
      $display("FAIL load_5: cur_div=%0d, required 5", cur_div);
    end
    en = 1'b1;
    tick();
    cap(10, co, tr);
    n_checks++;
    if (co[9:0] !== 10'b1110011100 || tr[9:0] !== 10'b1000010000) begin
      n_fail++;
      $display("FAIL wave_n5: clk=%b tick=%b, required 1110011100 1000010000", co[9:0], tr[9:0]);
    end
  endtask

  task automatic test_stop_restart();
    logic [31:0] co, tr;
    wait_idle();
    load_idle(8'd6);
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    cap(8, co, tr);
    n_checks++;
    if (co[7:0] !== 8'b11000000 || tr[7:0] !== 8'b00000000 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_n6: clk=%b tick=%b active=%b, required 11000000 00000000 0",
               co[7:0], tr[7:0], active);
    end
    en = 1'b1;
    tick();
    co = '0; tr = '0;
    for (int i = 0; i < 18; i++) begin
      co = {co[30:0], clk_out};
      tr = {tr[30:0], tick_rise};
      if (i == 2) en = 1'b0;
      if (i == 3) en = 1'b1;
      if (i < 17) tick();
    end
    n_checks++;
    if (co[17:0] !== 18'b111000111000111000 || tr[17:0] !== 18'b100000100000100000 ||
        active !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_reenable: clk=%b tick=%b active=%b, required 111000111000111000 100000100000100000 1",
               co[17:0], tr[17:0], active);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] co, tr;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 8'd8;
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b0 || cur_div !== 8'd6) begin
      n_fail++;
      $display("FAIL boundary_xfer_pend: ready=%b cur_div=%0d, required 0 and 6", cfg_if.cfg_ready, cur_div);
    end
    cap(14, co, tr);
    n_checks++;
    if (co[13:0] !== 14'b11100011110000 || tr[13:0] !== 14'b10000010000000) begin
      n_fail++;
      $display("FAIL boundary_xfer_wave: clk=%b tick=%b, required 11100011110000 10000010000000",
               co[13:0], tr[13:0]);
    end
    n_checks++;
    if (cur_div !== 8'd8 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL applied_8: cur_div=%0d ready=%b, required 8 and 1", cur_div, cfg_if.cfg_ready);
    end
    en = 1'b0;
    tick();
    cap(10, co, tr);
    n_checks++;
    if (co[9:0] !== 10'b1111000000 || tr[9:0] !== 10'b1000000000 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_stop: clk=%b tick=%b active=%b, required 1111000000 1000000000 0",
               co[9:0], tr[9:0], active);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] co, tr;
    en = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 8'd3;
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b0 || clk_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: ready=%b clk=%b, required 0 and 1", cfg_if.cfg_ready, clk_out);
    end
    rst = 1'b0; en = 1'b0;
    tick();
    n_checks++;
    if ({clk_out, tick_rise, active, cfg_if.cfg_ready} !== 4'b0001 || cur_div !== 8'd4) begin
      n_fail++;
      $display("FAIL mid_reset: clk/tick/active/ready=%b cur_div=%0d, required 0001 and 4",
               {clk_out, tick_rise, active, cfg_if.cfg_ready}, cur_div);
    end
    rst = 1'b1; en = 1'b1;
    tick();
    cap(8, co, tr);
    n_checks++;
    if (co[7:0] !== 8'b11001100 || tr[7:0] !== 8'b10001000 || cur_div !== 8'd4) begin
      n_fail++;
      $display("FAIL post_reset_n4: clk=%b tick=%b cur_div=%0d, required 11001100 10001000 4",
               co[7:0], tr[7:0], cur_div);
    end
  endtask

  task automatic test_max_div();
    int highs = 0;
    int ticks = 0;
    wait_idle();
    load_idle(8'd255);
    en = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) begin
      highs += int'(clk_out);
      ticks += int'(tick_rise);
      tick();
    end
    n_checks++;
    if (highs != 128 || ticks != 1) begin
      n_fail++;
      $display("FAIL max_div_period: highs=%0d ticks=%0d, required 128 and 1", highs, ticks);
    end
    n_checks++;
    if (clk_out !== 1'b1 || tick_rise !== 1'b1) begin
      n_fail++;
      $display("FAIL max_div_wrap: clk=%b tick=%b, required 1 and 1", clk_out, tick_rise);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ratio_change();
    test_clamp_odd();
    test_stop_restart();
    test_back_to_back();
    test_mid_reset();
    test_max_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
